// File: rtl/phy_pkg.sv
// Shared PHY definitions: BMC encoder state encoding and the line timing defaults
// that the BMC encoder and decoder both derive their cell timing from.
package phy_pkg;

    typedef enum logic [1:0] {
        PHY_BMC_IDLE = 2'd0,
        PHY_BMC_DATA = 2'd1,
        PHY_BMC_TAIL = 2'd2,
        PHY_BMC_HOLD = 2'd3
    } phy_bmc_state_e;

    localparam logic [10:0] BMC_HALF_PERIOD_DEF = 11'd4;
    localparam logic [10:0] BMC_HOLD_LOW_DEF    = 11'd8;

    // Decoder samples three quarters into the cell: 3*H/2 clocks after the boundary.
    function automatic logic [10:0] bmc_decode_period(input logic [10:0] half_period);
        return half_period + (half_period >> 1);
    endfunction

    localparam logic [10:0] BMC_DECODE_PERIOD = bmc_decode_period(BMC_HALF_PERIOD_DEF);

endpackage : phy_pkg

// File: rtl/phy_bmc_encoder.sv
// USB-PD BMC line encoder: one framer bit per UI in, BMC waveform plus CC driver
// enable out, followed by the end-of-frame tail and hold-low period.
module phy_bmc_encoder
    import phy_pkg::*;
#(
    parameter logic [10:0] BMC_HALF_PERIOD = BMC_HALF_PERIOD_DEF,
    parameter logic [10:0] BMC_HOLD_LOW    = BMC_HOLD_LOW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           phy_bmc_encoder_clr,
    input  logic           phy_bmc_encoder_start,
    input  logic           phy_bmc_encoder_in,
    input  logic           phy_bmc_encoder_last,
    output logic           phy_bmc_encoder_in_req,
    output logic           phy_bmc_encoder_out,
    output logic           phy_bmc_encoder_out_en,
    output logic           phy_bmc_encoder_busy,
    output logic           phy_bmc_encoder_done,
    output phy_bmc_state_e phy_bmc_encoder_state
);

    localparam logic [10:0] HALF_END = BMC_HALF_PERIOD - 11'd1;
    localparam logic [10:0] CELL_END = (BMC_HALF_PERIOD * 11'd2) - 11'd1;
    localparam logic [10:0] REQ_PRE  = (BMC_HALF_PERIOD * 11'd2) - 11'd3;
    localparam logic [10:0] HOLD_END = BMC_HOLD_LOW - 11'd1;

    phy_bmc_state_e state_q, state_d;
    logic [10:0]    cnt_q, cnt_d;
    logic           out_q, out_d;
    logic           out_en_q, out_en_d;
    logic           cur_bit_q, cur_bit_d;
    logic           cur_last_q, cur_last_d;
    logic           in_req_q, in_req_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PHY_BMC_IDLE;
            cnt_q      <= 11'd0;
            out_q      <= 1'b0;
            out_en_q   <= 1'b0;
            cur_bit_q  <= 1'b0;
            cur_last_q <= 1'b0;
            in_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            out_en_q   <= out_en_d;
            cur_bit_q  <= cur_bit_d;
            cur_last_q <= cur_last_d;
            in_req_q   <= in_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Bit handshake: in_req is a one-cycle request, high while cnt==2H-2 of a non-final
    // cell. The framer presents the next in/last on the edge closing that cycle and holds
    // them; the encoder samples them on the following edge (the one closing cnt==2H-1).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_en_d   = out_en_q;
        cur_bit_d  = cur_bit_q;
        cur_last_d = cur_last_q;
        in_req_d   = 1'b0;
        done_d     = 1'b0;

        if (phy_bmc_encoder_clr) begin
            state_d    = PHY_BMC_IDLE;
            cnt_d      = 11'd0;
            out_d      = 1'b0;
            out_en_d   = 1'b0;
            cur_bit_d  = 1'b0;
            cur_last_d = 1'b0;
        end else begin
            unique case (state_q)
                PHY_BMC_IDLE: begin
                    if (phy_bmc_encoder_start) begin
                        out_d      = ~out_q;
                        out_en_d   = 1'b1;
                        cur_bit_d  = phy_bmc_encoder_in;
                        cur_last_d = phy_bmc_encoder_last;
                        cnt_d      = 11'd0;
                        state_d    = PHY_BMC_DATA;
                    end
                end

                PHY_BMC_DATA: begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == HALF_END && cur_bit_q) begin
                        out_d = ~out_q;
                    end
                    if (cnt_q == REQ_PRE && !cur_last_q) begin
                        in_req_d = 1'b1;
                    end
                    if (cnt_q == CELL_END) begin
                        cnt_d = 11'd0;
                        if (cur_last_q) begin
                            state_d = PHY_BMC_TAIL;
                        end else begin
                            out_d      = ~out_q;
                            cur_bit_d  = phy_bmc_encoder_in;
                            cur_last_d = phy_bmc_encoder_last;
                        end
                    end
                end

                // A frame ending high needs one trailing half-UI before the line is parked low.
                PHY_BMC_TAIL: begin
                    if (!out_q) begin
                        cnt_d   = 11'd0;
                        state_d = PHY_BMC_HOLD;
                    end else if (cnt_q == HALF_END) begin
                        out_d   = 1'b0;
                        cnt_d   = 11'd0;
                        state_d = PHY_BMC_HOLD;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end

                PHY_BMC_HOLD: begin
                    if (cnt_q == HOLD_END) begin
                        out_en_d = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = 11'd0;
                        state_d  = PHY_BMC_IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end

                default: begin
                    state_d = PHY_BMC_IDLE;
                    cnt_d   = 11'd0;
                end
            endcase
        end

        busy_d = (state_d != PHY_BMC_IDLE);
    end

    assign phy_bmc_encoder_in_req = in_req_q;
    assign phy_bmc_encoder_out    = out_q;
    assign phy_bmc_encoder_out_en = out_en_q;
    assign phy_bmc_encoder_busy   = busy_q;
    assign phy_bmc_encoder_done   = done_q;
    assign phy_bmc_encoder_state  = state_q;

`ifndef SYNTHESIS
    // The line is never driven high while the CC driver is disabled.
    a_out_needs_en: assert property (@(posedge clk) disable iff (!rst_n)
        !out_en_q |-> !out_q);
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |-> (!busy_q && !out_en_q));
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> !done_q);
    a_req_busy: assert property (@(posedge clk) disable iff (!rst_n)
        in_req_q |-> busy_q);
`endif

endmodule : phy_bmc_encoder

// File: tb/tb_phy_bmc_encoder.sv
// Self-checking bench for phy_bmc_encoder: per-cycle comparison against a cell-level
// BMC waveform model, hand-derived frame table, corner sequences and random frames.
module tb_phy_bmc_encoder;
    import phy_pkg::*;

    localparam int H    = 4;
    localparam int HOLD = 8;
    localparam int UI   = 2 * H;

    logic           clk;
    logic           rst_n;
    logic           clr;
    logic           start;
    logic           din;
    logic           last;
    logic           in_req;
    logic           out;
    logic           out_en;
    logic           busy;
    logic           done;
    phy_bmc_state_e state;

    int checks = 0;
    int errors = 0;

    logic       frame_bits[$];
    logic [4:0] m_vec[$];
    logic       cap_out[$];

    typedef struct {
        logic [7:0] bits;
        int         n;
        int         done_cyc;
        int         n_req;
        int         n_trans;
    } vec_t;

    vec_t vecs[6];

    phy_bmc_encoder #(
        .BMC_HALF_PERIOD(11'(H)),
        .BMC_HOLD_LOW   (11'(HOLD))
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .phy_bmc_encoder_clr   (clr),
        .phy_bmc_encoder_start (start),
        .phy_bmc_encoder_in    (din),
        .phy_bmc_encoder_last  (last),
        .phy_bmc_encoder_in_req(in_req),
        .phy_bmc_encoder_out   (out),
        .phy_bmc_encoder_out_en(out_en),
        .phy_bmc_encoder_busy  (busy),
        .phy_bmc_encoder_done  (done),
        .phy_bmc_encoder_state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {out, out_en, in_req, done, busy};
    endfunction

    // Expected {out, out_en, in_req, done, busy} for cycles 1.. after start, built cell by cell.
    task automatic build_model();
        int   n = frame_bits.size();
        logic lvl = 1'b0;
        logic first_h;
        logic second_h;
        logic req;
        m_vec.delete();
        for (int k = 0; k < n; k++) begin
            first_h  = ~lvl;
            second_h = frame_bits[k] ? ~first_h : first_h;
            for (int j = 0; j < UI; j++) begin
                req = (j == UI - 2) && (k != n - 1);
                m_vec.push_back({(j < H) ? first_h : second_h, 1'b1, req, 1'b0, 1'b1});
            end
            lvl = second_h;
        end
        if (lvl) begin
            for (int j = 0; j < H; j++) m_vec.push_back(5'b11001);
        end else begin
            m_vec.push_back(5'b01001);
        end
        for (int j = 0; j < HOLD; j++) m_vec.push_back(5'b01001);
        m_vec.push_back(5'b00010);
    endtask

    // Called with the DUT idle in the current cycle (cycle 0); returns in the done cycle.
    task automatic run_frame(input int dup_at, output int done_cyc, output int n_req,
                             output int n_trans);
        int   n;
        int   idx;
        int   limit;
        logic prev_req;
        logic prev_out;
        logic [4:0] exp;
        build_model();
        n        = frame_bits.size();
        idx      = 0;
        cap_out.delete();
        start    = 1'b1;
        din      = frame_bits[0];
        last     = (n == 1);
        prev_req = 1'b0;
        prev_out = out;
        done_cyc = -1;
        n_req    = 0;
        n_trans  = 0;
        limit    = m_vec.size() + 16;
        for (int c = 1; c <= limit; c++) begin
            step();
            start = (c == dup_at);
            exp   = (c <= m_vec.size()) ? m_vec[c-1] : 5'b00000;
            check("frame_cycle", c, 32'(outs()), 32'(exp));
            cap_out.push_back(out);
            if (out != prev_out) n_trans++;
            prev_out = out;
            if (in_req) n_req++;
            if (prev_req && idx < n - 1) begin
                idx++;
                din  = frame_bits[idx];
                last = (idx == n - 1);
            end
            prev_req = in_req;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        din   = 1'b0;
        last  = 1'b0;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no done within %0d cycles, expected one", limit);
        end
    endtask

    task automatic load_vec(input vec_t v);
        frame_bits.delete();
        for (int k = 0; k < v.n; k++) frame_bits.push_back(v.bits[k]);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            check(name, i, {27'd0, outs()}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int r;
        int t;
        int nb;
        logic a;
        logic b;

        vecs[0] = '{bits: 8'b0000_0101, n: 3, done_cyc: 37, n_req: 2, n_trans: 6};
        vecs[1] = '{bits: 8'b0000_0000, n: 1, done_cyc: 21, n_req: 0, n_trans: 2};
        vecs[2] = '{bits: 8'b0000_0001, n: 1, done_cyc: 18, n_req: 0, n_trans: 2};
        vecs[3] = '{bits: 8'b0000_0000, n: 2, done_cyc: 26, n_req: 1, n_trans: 2};
        vecs[4] = '{bits: 8'b0000_0011, n: 2, done_cyc: 26, n_req: 1, n_trans: 4};
        vecs[5] = '{bits: 8'b0000_0110, n: 4, done_cyc: 42, n_req: 3, n_trans: 6};

        rst_n = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
        din   = 1'b0;
        last  = 1'b0;
        repeat (3) step();
        check("reset_outputs", 0, {27'd0, outs()}, 32'd0);
        check("reset_state", 0, 32'(state), 32'(PHY_BMC_IDLE));
        rst_n = 1'b1;
        check_quiet("idle_after_reset", 20);

        for (int i = 0; i < 6; i++) begin
            load_vec(vecs[i]);
            run_frame(-1, d, r, t);
            check("table_done_cycle", i, d, vecs[i].done_cyc);
            check("table_in_req_count", i, r, vecs[i].n_req);
            check("table_transitions", i, t, vecs[i].n_trans);
            step();
        end

        // A second start in the middle of DATA must leave the waveform untouched.
        load_vec(vecs[0]);
        run_frame(10, d, r, t);
        check("dup_start_done", 0, d, 37);
        check("dup_start_transitions", 0, t, 6);
        step();

        // clr in the middle of a frame: line and enable drop next cycle, no done follows.
        start = 1'b1;
        din   = 1'b1;
        last  = 1'b0;
        step();
        start = 1'b0;
        repeat (11) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_mid_data", 0, {27'd0, outs()}, 32'd0);
        check("clr_state", 0, 32'(state), 32'(PHY_BMC_IDLE));
        check_quiet("after_clr", 40);
        din = 1'b0;

        // clr wins over a start in the same cycle.
        start = 1'b1;
        clr   = 1'b1;
        step();
        start = 1'b0;
        clr   = 1'b0;
        check("clr_with_start", 0, {27'd0, outs()}, 32'd0);
        check_quiet("clr_with_start_after", 5);

        // Asynchronous reset mid-frame.
        load_vec(vecs[5]);
        start = 1'b1;
        din   = 1'b0;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_frame", 0, {27'd0, outs()}, 32'd0);
        step();
        rst_n = 1'b1;
        check_quiet("after_async_reset", 10);

        // Back-to-back: the second start lands in the first frame's done cycle.
        load_vec(vecs[0]);
        run_frame(-1, d, r, t);
        check("b2b_first_done", 0, d, 37);
        check("b2b_out_en_gap", 0, 32'(out_en), 32'd0);
        load_vec(vecs[5]);
        run_frame(-1, d, r, t);
        check("b2b_second_done", 0, d, 42);

        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 12);
            frame_bits.delete();
            for (int k = 0; k < nb; k++) frame_bits.push_back(1'($urandom_range(0, 1)));
            run_frame(-1, d, r, t);
            check("rand_done_cycle", f, d, m_vec.size());
            check("rand_in_req_count", f, r, nb - 1);
            repeat ($urandom_range(0, 3)) step();
        end

        // Loopback: decode the captured line by comparing the two half-cells of each UI.
        frame_bits.delete();
        for (int k = 0; k < 64; k++) frame_bits.push_back(1'($urandom_range(0, 1)));
        run_frame(-1, d, r, t);
        check("loopback_in_req_count", 0, r, 63);
        for (int k = 0; k < 64; k++) begin
            if (UI * k + UI - 2 < cap_out.size()) begin
                a = cap_out[UI * k + H / 2];
                b = cap_out[UI * k + H + H / 2];
                check("loopback_bit", k, 32'(a ^ b), 32'(frame_bits[k]));
            end else begin
                check("loopback_capture_len", k, cap_out.size(), UI * k + UI - 1);
            end
        end
        check_quiet("final_idle", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_phy_bmc_encoder
